// File: rtl/stdp_pkg.sv
// Shared defaults and helpers for the STDP synapse array.
package stdp_pkg;

  localparam int unsigned DEF_N_PRE      = 5;
  localparam int unsigned DEF_W_WIDTH    = 8;
  localparam int unsigned DEF_V_WIDTH    = 10;
  localparam int unsigned DEF_T_WIDTH    = 4;
  localparam int unsigned DEF_THRESHOLD  = 200;
  localparam int unsigned DEF_LEAK_SHIFT = 1;
  localparam int unsigned DEF_REFRACT    = 2;
  localparam int unsigned DEF_A_PLUS     = 4;
  localparam int unsigned DEF_A_MINUS    = 3;
  localparam int unsigned DEF_W_INIT     = 32;

  // Clamp a signed intermediate result into [0, hi].
  function automatic int unsigned clamp_range(input int val, input int unsigned hi);
    if (val < 0) begin
      return 0;
    end else if (val > int'(hi)) begin
      return hi;
    end else begin
      return $unsigned(val);
    end
  endfunction

endpackage

// File: rtl/lif_core.sv
// Leaky integrate-and-fire neuron: leak, integrate summed drive, saturate,
// threshold and hold off for a fixed refractory period after each spike.
module lif_core #(
  parameter int unsigned V_WIDTH    = 10,
  parameter int unsigned IN_W       = 12,
  parameter int unsigned THRESHOLD  = 200,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned REFRACT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    i_drive,
  output logic [V_WIDTH-1:0] o_membrane,
  output logic               o_spike,
  output logic               o_fire_c
);

  localparam int unsigned V_MAX = (1 << V_WIDTH) - 1;
  localparam int unsigned ACC_W = ((V_WIDTH > IN_W) ? V_WIDTH : IN_W) + 2;
  localparam int unsigned RC_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  logic [V_WIDTH-1:0] r_v;
  logic               r_spike;
  logic [RC_W-1:0]    r_refr;

  logic [ACC_W-1:0]   w_acc;
  logic [V_WIDTH-1:0] w_v_sat;
  logic               w_fire;

  // Candidate next membrane value, saturated, and the fire decision.
  always_comb begin
    w_acc   = ACC_W'(r_v) - ACC_W'(r_v >> LEAK_SHIFT) + ACC_W'(i_drive);
    w_v_sat = (w_acc > ACC_W'(V_MAX)) ? V_WIDTH'(V_MAX) : w_acc[V_WIDTH-1:0];
    w_fire  = (r_refr == '0) && (ACC_W'(w_v_sat) >= ACC_W'(THRESHOLD));
  end

  // Membrane, spike and refractory countdown registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v     <= '0;
      r_spike <= 1'b0;
      r_refr  <= '0;
    end else if (r_refr != '0) begin
      r_v     <= '0;
      r_spike <= 1'b0;
      r_refr  <= r_refr - RC_W'(1);
    end else if (w_fire) begin
      r_v     <= '0;
      r_spike <= 1'b1;
      r_refr  <= RC_W'(REFRACT);
    end else begin
      r_v     <= w_v_sat;
      r_spike <= 1'b0;
    end
  end

  assign o_membrane = r_v;
  assign o_spike    = r_spike;
  assign o_fire_c   = w_fire;

endmodule

// File: rtl/stdp_synapse_array.sv
// N_PRE plastic synapses feeding one LIF neuron; pair-based STDP with
// saturating spike-timing counters, plus a direct weight-load port.
module stdp_synapse_array
  import stdp_pkg::*;
#(
  parameter int unsigned N_PRE      = DEF_N_PRE,
  parameter int unsigned W_WIDTH    = DEF_W_WIDTH,
  parameter int unsigned V_WIDTH    = DEF_V_WIDTH,
  parameter int unsigned T_WIDTH    = DEF_T_WIDTH,
  parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned REFRACT    = DEF_REFRACT,
  parameter int unsigned A_PLUS     = DEF_A_PLUS,
  parameter int unsigned A_MINUS    = DEF_A_MINUS,
  parameter int unsigned W_INIT     = DEF_W_INIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PRE-1:0]           pre_spike,
  input  logic [7:0]                 ext_current,
  input  logic                       learn_en,
  input  logic                       w_load_en,
  input  logic [$clog2(N_PRE)-1:0]   w_load_idx,
  input  logic [W_WIDTH-1:0]         w_load_val,
  output logic                       post_spike,
  output logic [V_WIDTH-1:0]         membrane,
  output logic [N_PRE*W_WIDTH-1:0]   weights,
  output logic                       update_flag
);

  localparam int unsigned IDX_W    = $clog2(N_PRE);
  localparam int unsigned W_MAX    = (1 << W_WIDTH) - 1;
  localparam int unsigned T_MAX    = (1 << T_WIDTH) - 1;
  localparam int unsigned T_HALF   = T_MAX / 2;
  localparam int unsigned DRV_BASE = (W_WIDTH > 8) ? W_WIDTH : 8;
  localparam int unsigned SUM_W    = DRV_BASE + $clog2(N_PRE + 1) + 1;

  logic [W_WIDTH-1:0] r_w       [N_PRE];
  logic [T_WIDTH-1:0] r_t_pre   [N_PRE];
  logic [T_WIDTH-1:0] r_t_post;
  logic               r_update_flag;

  logic [W_WIDTH-1:0] w_w_next  [N_PRE];
  logic [W_WIDTH-1:0] w_learned [N_PRE];
  int                 w_dp      [N_PRE];
  int                 w_dm      [N_PRE];
  logic               w_changed;
  logic [SUM_W-1:0]   w_drive;
  logic               w_fire;

  // Total neuron drive: bias current plus weights of synapses spiking now.
  always_comb begin
    w_drive = SUM_W'(ext_current);
    for (int i = 0; i < N_PRE; i++) begin
      if (pre_spike[i]) begin
        w_drive = w_drive + SUM_W'(r_w[i]);
      end
    end
  end

  lif_core #(
    .V_WIDTH    (V_WIDTH),
    .IN_W       (SUM_W),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT)
  ) u_lif (
    .clk        (clk),
    .rst        (rst),
    .i_drive    (w_drive),
    .o_membrane (membrane),
    .o_spike    (post_spike),
    .o_fire_c   (w_fire)
  );

  // Per-synapse STDP step from pre-edge timers, then load override.
  always_comb begin
    w_changed = 1'b0;
    for (int i = 0; i < N_PRE; i++) begin
      w_dp[i] = 0;
      w_dm[i] = 0;
      if (learn_en && post_spike && (r_t_pre[i] != T_WIDTH'(T_MAX))) begin
        w_dp[i] = (r_t_pre[i] < T_WIDTH'(T_HALF)) ? int'(A_PLUS) : int'(A_PLUS >> 1);
      end
      if (learn_en && pre_spike[i] && (r_t_post != T_WIDTH'(T_MAX))) begin
        w_dm[i] = (r_t_post < T_WIDTH'(T_HALF)) ? int'(A_MINUS) : int'(A_MINUS >> 1);
      end
      w_learned[i] = W_WIDTH'(clamp_range(int'(r_w[i]) + w_dp[i] - w_dm[i], W_MAX));
      if (w_load_en && (w_load_idx == IDX_W'(i))) begin
        w_w_next[i] = w_load_val;
      end else begin
        w_w_next[i] = w_learned[i];
        if (w_learned[i] != r_w[i]) begin
          w_changed = 1'b1;
        end
      end
    end
  end

  // Weight registers and learning-update flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PRE; i++) begin
        r_w[i] <= W_WIDTH'(W_INIT);
      end
      r_update_flag <= 1'b0;
    end else begin
      for (int i = 0; i < N_PRE; i++) begin
        r_w[i] <= w_w_next[i];
      end
      r_update_flag <= w_changed;
    end
  end

  // Saturating time-since-spike counters; all-ones means no recent spike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PRE; i++) begin
        r_t_pre[i] <= T_WIDTH'(T_MAX);
      end
      r_t_post <= T_WIDTH'(T_MAX);
    end else begin
      for (int i = 0; i < N_PRE; i++) begin
        if (pre_spike[i]) begin
          r_t_pre[i] <= '0;
        end else if (r_t_pre[i] != T_WIDTH'(T_MAX)) begin
          r_t_pre[i] <= r_t_pre[i] + T_WIDTH'(1);
        end
      end
      if (w_fire) begin
        r_t_post <= '0;
      end else if (r_t_post != T_WIDTH'(T_MAX)) begin
        r_t_post <= r_t_post + T_WIDTH'(1);
      end
    end
  end

  // Flatten the weight array onto the output bus.
  always_comb begin
    weights = '0;
    for (int i = 0; i < N_PRE; i++) begin
      weights[i*W_WIDTH +: W_WIDTH] = r_w[i];
    end
  end

  assign update_flag = r_update_flag;

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Bench for stdp_synapse_array: directed scenarios plus random stimulus
// checked against an integer behavioural model of the neuron and STDP rules.
module tb_stdp_synapse_array;

  localparam int N    = 5;
  localparam int VMAX = 1023;
  localparam int WMAX = 255;
  localparam int TMAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  pre_spike;
  logic [7:0]  ext_current;
  logic        learn_en;
  logic        w_load_en;
  logic [2:0]  w_load_idx;
  logic [7:0]  w_load_val;
  logic        post_spike;
  logic [9:0]  membrane;
  logic [39:0] weights;
  logic        update_flag;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_v, m_refr, m_post, m_flag, m_tpost;
  int m_w    [N];
  int m_tpre [N];

  stdp_synapse_array dut (
    .clk         (clk),
    .rst         (rst),
    .pre_spike   (pre_spike),
    .ext_current (ext_current),
    .learn_en    (learn_en),
    .w_load_en   (w_load_en),
    .w_load_idx  (w_load_idx),
    .w_load_val  (w_load_val),
    .post_spike  (post_spike),
    .membrane    (membrane),
    .weights     (weights),
    .update_flag (update_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_w(input int i);
    return weights[i*8 +: 8];
  endfunction

  task automatic model_reset();
    m_v = 0; m_refr = 0; m_post = 0; m_flag = 0; m_tpost = TMAX;
    for (int i = 0; i < N; i++) begin
      m_w[i] = 32;
      m_tpre[i] = TMAX;
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [4:0] pre, input int ext, input logic learn,
                      input logic ld, input int idx, input int val);
    int nw [N];
    int flag, sum, v, nv, nrefr, fire, dp, dm, t;
    pre_spike = pre; ext_current = 8'(ext); learn_en = learn;
    w_load_en = ld; w_load_idx = 3'(idx); w_load_val = 8'(val);
    flag = 0;
    for (int i = 0; i < N; i++) begin
      dp = 0; dm = 0;
      if (learn && m_post == 1 && m_tpre[i] < TMAX) dp = (m_tpre[i] < TMAX / 2) ? 4 : 2;
      if (learn && pre[i] && m_tpost < TMAX) dm = (m_tpost < TMAX / 2) ? 3 : 1;
      t = m_w[i] + dp - dm;
      if (t < 0) t = 0;
      if (t > WMAX) t = WMAX;
      if (ld && idx == i) nw[i] = val;
      else begin
        nw[i] = t;
        if (t != m_w[i]) flag = 1;
      end
    end
    fire = 0;
    if (m_refr > 0) begin
      nv = 0; nrefr = m_refr - 1;
    end else begin
      sum = ext;
      for (int i = 0; i < N; i++) if (pre[i]) sum += m_w[i];
      v = m_v - m_v / 2 + sum;
      if (v > VMAX) v = VMAX;
      if (v >= 200) begin nv = 0; fire = 1; nrefr = 2; end
      else begin nv = v; nrefr = 0; end
    end
    for (int i = 0; i < N; i++) begin
      m_tpre[i] = pre[i] ? 0 : ((m_tpre[i] < TMAX) ? m_tpre[i] + 1 : TMAX);
      m_w[i] = nw[i];
    end
    m_tpost = fire ? 0 : ((m_tpost < TMAX) ? m_tpost + 1 : TMAX);
    m_v = nv; m_refr = nrefr; m_post = fire; m_flag = flag;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    pre_spike = '0; ext_current = '0; learn_en = 1'b0;
    w_load_en = 1'b0; w_load_idx = '0; w_load_val = '0;
    rst = 1'b1;
    #2;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (membrane !== 10'd0 || post_spike !== 1'b0 || update_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init mem=%0d post=%0b flag=%0b required 0/0/0", membrane, post_spike, update_flag);
    end
    for (int k = 0; k < 6; k++) step(5'($urandom & $urandom), 120, 1'b1, 1'b0, 0, 0);
    rst = 1'b1;
    #2;
    n_checks++;
    if (membrane !== 10'd0 || post_spike !== 1'b0 || update_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid mem=%0d post=%0b flag=%0b required 0/0/0", membrane, post_spike, update_flag);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut_w(i) !== 8'd32) begin
        n_fail++;
        $display("FAIL reset_w%0d got=%0d required=32", i, dut_w(i));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_integrate_fire();
    int exp_m [6];
    int exp_p [6];
    exp_m = '{120, 180, 0, 0, 0, 120};
    exp_p = '{0, 0, 1, 0, 0, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(5'b0, 120, 1'b0, 1'b0, 0, 0);
      n_checks++;
      if (membrane !== 10'(exp_m[k]) || post_spike !== 1'(exp_p[k])) begin
        n_fail++;
        $display("FAIL lif_cycle%0d mem=%0d post=%0b required %0d/%0d", k, membrane, post_spike, exp_m[k], exp_p[k]);
      end
    end
  endtask

  task automatic test_ltp();
    do_reset();
    step(5'b0, 120, 1'b1, 1'b0, 0, 0);
    step(5'b00001, 120, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (post_spike !== 1'b1 || membrane !== 10'd0 || update_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL ltp_fire post=%0b mem=%0d flag=%0b required 1/0/0", post_spike, membrane, update_flag);
    end
    step(5'b0, 0, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (dut_w(0) !== 8'd36 || update_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL ltp_w0 w0=%0d flag=%0b required 36/1", dut_w(0), update_flag);
    end
    for (int i = 1; i < N; i++) begin
      n_checks++;
      if (dut_w(i) !== 8'd32) begin
        n_fail++;
        $display("FAIL ltp_other_w%0d got=%0d required=32", i, dut_w(i));
      end
    end
    step(5'b0, 0, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (update_flag !== 1'b0 || dut_w(0) !== 8'd36) begin
      n_fail++;
      $display("FAIL ltp_flag_pulse flag=%0b w0=%0d required 0/36", update_flag, dut_w(0));
    end
  endtask

  task automatic test_ltd();
    int gap [2];
    int expw [2];
    gap  = '{2, 10};
    expw = '{29, 31};
    for (int s = 0; s < 2; s++) begin
      do_reset();
      for (int k = 0; k < 3; k++) step(5'b0, 120, 1'b1, 1'b0, 0, 0);
      n_checks++;
      if (post_spike !== 1'b1) begin
        n_fail++;
        $display("FAIL ltd_fire%0d post=%0b required 1", s, post_spike);
      end
      for (int k = 0; k < gap[s]; k++) step(5'b0, 0, 1'b1, 1'b0, 0, 0);
      step(5'b00010, 0, 1'b1, 1'b0, 0, 0);
      n_checks++;
      if (dut_w(1) !== 8'(expw[s]) || update_flag !== 1'b1) begin
        n_fail++;
        $display("FAIL ltd_tpost%0d w1=%0d flag=%0b required %0d/1", gap[s], dut_w(1), update_flag, expw[s]);
      end
    end
  endtask

  task automatic test_clamp();
    do_reset();
    step(5'b0, 0, 1'b1, 1'b1, 2, 254);
    n_checks++;
    if (dut_w(2) !== 8'd254 || update_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_load2 w2=%0d flag=%0b required 254/0", dut_w(2), update_flag);
    end
    step(5'b00100, 0, 1'b1, 1'b0, 0, 0);
    step(5'b0, 0, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (dut_w(2) !== 8'd255 || update_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_ltp_max w2=%0d flag=%0b required 255/1", dut_w(2), update_flag);
    end
    step(5'b0, 0, 1'b1, 1'b1, 3, 1);
    n_checks++;
    if (dut_w(3) !== 8'd1 || update_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_load3 w3=%0d flag=%0b required 1/0", dut_w(3), update_flag);
    end
    step(5'b01000, 0, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (dut_w(3) !== 8'd0 || update_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_ltd_min w3=%0d flag=%0b required 0/1", dut_w(3), update_flag);
    end
    step(5'b01000, 0, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if (dut_w(3) !== 8'd0 || update_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_noop w3=%0d flag=%0b required 0/0", dut_w(3), update_flag);
    end
  endtask

  task automatic test_learn_disable();
    int expw [N];
    do_reset();
    step(5'b0, 120, 1'b0, 1'b0, 0, 0);
    step(5'b00001, 120, 1'b0, 1'b0, 0, 0);
    step(5'b00010, 0, 1'b0, 1'b0, 0, 0);
    step(5'b00010, 0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut_w(i) !== 8'd32 || update_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL nolearn_w%0d w=%0d flag=%0b required 32/0", i, dut_w(i), update_flag);
      end
    end
    do_reset();
    step(5'b0, 120, 1'b1, 1'b0, 0, 0);
    step(5'b00011, 120, 1'b1, 1'b0, 0, 0);
    step(5'b0, 0, 1'b1, 1'b1, 0, 77);
    expw = '{77, 36, 32, 32, 32};
    n_checks++;
    if (update_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL load_wins_flag flag=%0b required 1", update_flag);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut_w(i) !== 8'(expw[i])) begin
        n_fail++;
        $display("FAIL load_wins_w%0d got=%0d required=%0d", i, dut_w(i), expw[i]);
      end
    end
    step(5'b0, 0, 1'b1, 1'b1, 6, 200);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (dut_w(i) !== 8'(expw[i]) || update_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL load_oob_w%0d w=%0d flag=%0b required %0d/0", i, dut_w(i), update_flag, expw[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] pre;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      pre = 5'($urandom & $urandom);
      step(pre, $urandom_range(0, 90), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), $urandom_range(0, 7), $urandom_range(0, 255));
      n_checks++;
      if (membrane !== 10'(m_v) || post_spike !== 1'(m_post) || update_flag !== 1'(m_flag)) begin
        n_fail++;
        $display("FAIL rand_neuron cyc=%0d mem=%0d post=%0b flag=%0b required %0d/%0d/%0d",
                 k, membrane, post_spike, update_flag, m_v, m_post, m_flag);
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (dut_w(i) !== 8'(m_w[i])) begin
          n_fail++;
          $display("FAIL rand_w%0d cyc=%0d got=%0d required=%0d", i, k, dut_w(i), m_w[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_integrate_fire();
    test_ltp();
    test_ltd();
    test_clamp();
    test_learn_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
